// File: rtl/adc_capture_arbiter_pkg.sv
// Shared types and constants for the ADC row capture scheduler.
package adc_capture_pkg;

    typedef enum logic [1:0] {StIdle, StHeader, StStream, StTrailer} state_e;

    localparam logic [3:0]  HDR_TAG_DEF = 4'hA;
    localparam logic [3:0]  TRL_TAG_DEF = 4'hF;
    localparam logic [1:0]  CH_ADC1     = 2'b01;
    localparam logic [1:0]  CH_ADC2     = 2'b10;
    localparam int unsigned CH_LSB      = 30;
    localparam int unsigned IDX_LSB     = 16;
    localparam logic [11:0] CNT_MAX     = 12'hFFF;

    // Header and trailer share one layout: tag, row address, 12-bit payload.
    function automatic logic [31:0] ctrl_word(logic [3:0] tag, logic [9:0] addr,
                                              logic [11:0] low);
        return {tag, 2'b00, addr, 4'h0, low};
    endfunction

endpackage

// File: rtl/adc_capture_arbiter_if.sv
// Row control, sample streams, FIFO write port and status of the capture arbiter.
interface adc_capture_arbiter_if #(
    parameter int unsigned ADC_W = 12
);
    logic             row_start;
    logic [9:0]       row_addr;
    logic [11:0]      samples_per_row;
    logic             adc1_valid;
    logic [ADC_W-1:0] adc1_data;
    logic             adc2_valid;
    logic [ADC_W-1:0] adc2_data;
    logic             fifo_full;
    logic             fifo_wr;
    logic [31:0]      fifo_din;
    logic             busy;
    logic             row_done;
    logic             overflow;
    logic             row_overlap;

    modport master (
        output row_start, row_addr, samples_per_row, adc1_valid, adc1_data,
               adc2_valid, adc2_data, fifo_full,
        input  fifo_wr, fifo_din, busy, row_done, overflow, row_overlap
    );

    modport slave (
        input  row_start, row_addr, samples_per_row, adc1_valid, adc1_data,
               adc2_valid, adc2_data, fifo_full,
        output fifo_wr, fifo_din, busy, row_done, overflow, row_overlap
    );

endinterface

// File: rtl/adc_capture_arbiter_sample_skid_fifo.sv
// Small synchronous per-channel sample buffer; a push into a full buffer succeeds
// when a pop happens on the same edge.
module sample_skid_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, rd_q;
    logic             do_push, do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/adc_capture_arbiter.sv
// Row-framed capture scheduler: header, round-robin ADC1/ADC2 data words, trailer
// with drop count, all funnelled into one capture FIFO write port.
module adc_capture_arbiter
    import adc_capture_pkg::*;
#(
    parameter int unsigned ADC_W     = 12,
    parameter int unsigned BUF_DEPTH = 4,
    parameter logic [3:0]  HDR_TAG   = HDR_TAG_DEF,
    parameter logic [3:0]  TRL_TAG   = TRL_TAG_DEF
) (
    input logic                  adc1_out_clk,
    input logic                  rst,
    adc_capture_arbiter_if.slave bus
);
    localparam int unsigned EW = ADC_W + 12;

    state_e           state_q, state_d;
    logic [9:0]       addr_q, addr_d;
    logic [11:0]      spr_q, spr_d, drop_q, drop_d;
    logic [1:0][11:0] acc_q, acc_d;
    logic             prio_q, prio_d, ovf_q, ovf_d, ovl_q, ovl_d;
    logic [1:0]       vld, push, pop, grant, buf_full, buf_empty;
    logic [ADC_W-1:0] smp [2];
    logic [EW-1:0]    buf_din [2];
    logic [EW-1:0]    buf_dout [2];
    logic [EW-1:0]    head;
    logic             all_in;

    assign vld    = {bus.adc2_valid, bus.adc1_valid};
    assign smp[0] = bus.adc1_data;
    assign smp[1] = bus.adc2_data;

    for (genvar c = 0; c < 2; c++) begin : g_buf
        assign buf_din[c] = {acc_q[c], smp[c]};
        sample_skid_fifo #(.WIDTH(EW), .DEPTH(BUF_DEPTH)) u_buf (
            .clk   (adc1_out_clk),
            .rst   (rst),
            .push  (push[c]),
            .pop   (pop[c]),
            .din   (buf_din[c]),
            .dout  (buf_dout[c]),
            .full  (buf_full[c]),
            .empty (buf_empty[c])
        );
    end

    // prio_q == 0 favours ADC1; a lone non-empty channel always wins.
    assign grant[0] = !buf_empty[0] && (buf_empty[1] || !prio_q);
    assign grant[1] = !buf_empty[1] && !grant[0];
    assign head     = grant[1] ? buf_dout[1] : buf_dout[0];
    assign all_in   = (acc_q[0] == spr_q) && (acc_q[1] == spr_q) && (&buf_empty);

    assign bus.busy        = (state_q != StIdle);
    assign bus.overflow    = ovf_q;
    assign bus.row_overlap = ovl_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        spr_d        = spr_q;
        acc_d        = acc_q;
        drop_d       = drop_q;
        prio_d       = prio_q;
        ovf_d        = ovf_q;
        ovl_d        = ovl_q;
        push         = '0;
        pop          = '0;
        bus.fifo_wr  = 1'b0;
        bus.fifo_din = '0;
        bus.row_done = 1'b0;

        if (bus.row_start && state_q != StIdle) ovl_d = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (bus.row_start) begin
                    addr_d  = bus.row_addr;
                    spr_d   = bus.samples_per_row;
                    acc_d   = '0;
                    drop_d  = '0;
                    state_d = StHeader;
                end
            end
            StHeader: begin
                if (!bus.fifo_full) begin
                    bus.fifo_wr  = 1'b1;
                    bus.fifo_din = ctrl_word(HDR_TAG, addr_q, spr_q);
                    state_d      = StStream;
                end
            end
            StStream: begin
                if (!bus.fifo_full && !(&buf_empty)) begin
                    bus.fifo_wr                   = 1'b1;
                    pop                           = grant;
                    prio_d                        = grant[0];
                    bus.fifo_din[CH_LSB +: 2]     = grant[1] ? CH_ADC2 : CH_ADC1;
                    bus.fifo_din[IDX_LSB +: 12]   = head[ADC_W +: 12];
                    bus.fifo_din[ADC_W-1:0]       = head[ADC_W-1:0];
                end else if (!bus.fifo_full && all_in) begin
                    state_d = StTrailer;
                end
            end
            StTrailer: begin
                if (!bus.fifo_full) begin
                    bus.fifo_wr  = 1'b1;
                    bus.fifo_din = ctrl_word(TRL_TAG, addr_q, drop_q);
                    bus.row_done = 1'b1;
                    state_d      = StIdle;
                end
            end
        endcase

        // Drops still consume a sample slot so the row always terminates.
        if (state_q == StHeader || state_q == StStream) begin
            for (int c = 0; c < 2; c++) begin
                if (vld[c] && acc_q[c] < spr_q) begin
                    acc_d[c] = acc_q[c] + 12'd1;
                    if (!buf_full[c] || pop[c]) begin
                        push[c] = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                        if (drop_d != CNT_MAX) drop_d = drop_d + 12'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge adc1_out_clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            spr_q   <= '0;
            acc_q   <= '0;
            drop_q  <= '0;
            prio_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ovl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            spr_q   <= spr_d;
            acc_q   <= acc_d;
            drop_q  <= drop_d;
            prio_q  <= prio_d;
            ovf_q   <= ovf_d;
            ovl_q   <= ovl_d;
        end
    end

endmodule

// File: tb/tb_adc_capture_arbiter.sv
// Directed bench for adc_capture_arbiter: captured FIFO words vs hand-computed lists.
module tb_adc_capture_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adc_capture_arbiter_if #(.ADC_W(12)) bus ();

    adc_capture_arbiter #(.ADC_W(12), .BUF_DEPTH(4)) dut (
        .adc1_out_clk (clk),
        .rst          (rst),
        .bus          (bus)
    );

    int          checks   = 0;
    int          errors   = 0;
    int          done_cnt = 0;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];

    // Writes take effect on the next rising edge; capture them mid-cycle.
    always @(negedge clk) begin
        if (!rst && bus.fifo_wr) got_q.push_back(bus.fifo_din);
        if (bus.row_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.row_start       = 1'b0;
        bus.row_addr        = '0;
        bus.samples_per_row = '0;
        bus.adc1_valid      = 1'b0;
        bus.adc1_data       = '0;
        bus.adc2_valid      = 1'b0;
        bus.adc2_data       = '0;
        bus.fifo_full       = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic start_row(input logic [9:0] addr, input logic [11:0] spr);
        bus.row_addr        = addr;
        bus.samples_per_row = spr;
        bus.row_start       = 1'b1;
        tick();
        bus.row_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n0;
        n0 = done_cnt;
        for (int i = 0; i < 60 && done_cnt == n0; i++) tick();
        check({tag, "_done"}, 32'(done_cnt - n0), 32'd1);
    endtask

    task automatic compare_words(input string tag);
        check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_w%0d", tag, i),
                  (i < got_q.size()) ? got_q[i] : 32'hDEAD_DEAD, exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        // Reset values
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        check("rst_fifo_wr", 32'(bus.fifo_wr), 32'd0);
        check("rst_fifo_din", bus.fifo_din, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_row_done", 32'(bus.row_done), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_overlap", 32'(bus.row_overlap), 32'd0);
        rst = 1'b0;
        tick();

        // Basic row: both channels every cycle, strict alternation
        start_row(10'd5, 12'd3);
        for (int i = 0; i < 3; i++) begin
            bus.adc1_valid = 1'b1;
            bus.adc1_data  = 12'(32'h100 + i);
            bus.adc2_valid = 1'b1;
            bus.adc2_data  = 12'(32'h200 + i);
            tick();
        end
        bus.adc1_valid = 1'b0;
        bus.adc2_valid = 1'b0;
        wait_done("basic");
        exp_q = '{32'hA005_0003, 32'h4000_0100, 32'h8000_0200, 32'h4001_0101,
                  32'h8001_0201, 32'h4002_0102, 32'h8002_0202, 32'hF005_0000};
        compare_words("basic");
        check("basic_idle", 32'(bus.busy), 32'd0);

        // Zero-length row
        start_row(10'd10, 12'd0);
        wait_done("zero");
        exp_q = '{32'hA00A_0000, 32'hF00A_0000};
        compare_words("zero");

        // Backpressure: ADC1 overruns its buffer while the FIFO is full
        check("bp_ovf_before", 32'(bus.overflow), 32'd0);
        bus.fifo_full = 1'b1;
        start_row(10'd3, 12'd6);
        for (int i = 0; i < 6; i++) begin
            bus.adc1_valid = 1'b1;
            bus.adc1_data  = 12'(32'h11 + i);
            tick();
        end
        bus.adc1_valid = 1'b0;
        repeat (4) tick();
        check("bp_no_write", 32'(got_q.size()), 32'd0);
        bus.fifo_full = 1'b0;
        repeat (8) tick();
        for (int i = 0; i < 6; i++) begin
            bus.adc2_valid = 1'b1;
            bus.adc2_data  = 12'(32'h21 + i);
            tick();
        end
        bus.adc2_valid = 1'b0;
        wait_done("bp");
        check("bp_overflow", 32'(bus.overflow), 32'd1);
        exp_q = '{32'hA003_0006, 32'h4000_0011, 32'h4001_0012, 32'h4002_0013,
                  32'h4003_0014, 32'h8000_0021, 32'h8001_0022, 32'h8002_0023,
                  32'h8003_0024, 32'h8004_0025, 32'h8005_0026, 32'hF003_0002};
        compare_words("bp");

        // Overlapping row_start during STREAM is ignored but flagged
        start_row(10'd7, 12'd1);
        bus.adc1_valid = 1'b1;
        bus.adc1_data  = 12'h0AA;
        bus.adc2_valid = 1'b1;
        bus.adc2_data  = 12'h0BB;
        tick();
        bus.adc1_valid = 1'b0;
        bus.adc2_valid = 1'b0;
        start_row(10'd9, 12'd2);
        wait_done("ovl");
        repeat (4) tick();
        check("ovl_flag", 32'(bus.row_overlap), 32'd1);
        check("ovl_idle", 32'(bus.busy), 32'd0);
        exp_q = '{32'hA007_0001, 32'h4000_00AA, 32'h8000_00BB, 32'hF007_0000};
        compare_words("ovl");

        // Idle and excess samples are neither written nor counted as drops
        do_reset();
        check("rst2_overflow", 32'(bus.overflow), 32'd0);
        check("rst2_overlap", 32'(bus.row_overlap), 32'd0);
        bus.adc1_valid = 1'b1;
        bus.adc1_data  = 12'h099;
        repeat (3) tick();
        bus.adc1_valid = 1'b0;
        start_row(10'd2, 12'd2);
        for (int i = 0; i < 5; i++) begin
            bus.adc1_valid = 1'b1;
            bus.adc1_data  = 12'(32'h31 + i);
            tick();
        end
        bus.adc1_valid = 1'b0;
        repeat (6) tick();
        check("excess_overflow", 32'(bus.overflow), 32'd0);
        check("excess_busy", 32'(bus.busy), 32'd1);
        exp_q = '{32'hA002_0002, 32'h4000_0031, 32'h4001_0032};
        compare_words("excess");

        // Reset mid-row with buffered samples
        do_reset();
        start_row(10'd4, 12'd3);
        tick();
        bus.fifo_full  = 1'b1;
        bus.adc1_valid = 1'b1;
        bus.adc1_data  = 12'h041;
        tick();
        bus.adc1_data = 12'h042;
        tick();
        bus.adc1_valid = 1'b0;
        rst            = 1'b1;
        bus.fifo_full  = 1'b0;
        tick();
        check("midrst_fifo_wr", 32'(bus.fifo_wr), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        got_q.delete();
        tick();
        start_row(10'd6, 12'd1);
        bus.adc1_valid = 1'b1;
        bus.adc1_data  = 12'h051;
        bus.adc2_valid = 1'b1;
        bus.adc2_data  = 12'h061;
        tick();
        bus.adc1_valid = 1'b0;
        bus.adc2_valid = 1'b0;
        wait_done("after_rst");
        exp_q = '{32'hA006_0001, 32'h4000_0051, 32'h8000_0061, 32'hF006_0000};
        compare_words("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
